// File: rtl/fp_cmp32_arbiter.sv
// rtl/fp_cmp32_arbiter.sv - round-robin arbiter sharing one fpCompare32 unit between NREQ requesters
module fp_cmp32_arbiter #(
    parameter int NREQ = 4,
    parameter int TAGW = 4,
    parameter int IDW  = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   ce,
    input  logic [NREQ-1:0]        req_valid,
    output logic [NREQ-1:0]        req_ready,
    input  logic [NREQ*32-1:0]     req_a,
    input  logic [NREQ*32-1:0]     req_b,
    input  logic [NREQ*TAGW-1:0]   req_tag,
    output logic                   resp_valid,
    input  logic                   resp_ready,
    output logic [IDW-1:0]         resp_id,
    output logic [TAGW-1:0]        resp_tag,
    output logic [15:0]            resp_o,
    output logic                   resp_nan,
    output logic                   resp_snan,
    output logic                   busy
);

    // issue stage
    logic [31:0]      s1_a_q, s1_b_q;
    logic [IDW-1:0]   s1_id_q;
    logic [TAGW-1:0]  s1_tag_q;
    logic             s1_v_q;

    // response stage
    logic             resp_valid_q;
    logic [IDW-1:0]   resp_id_q;
    logic [TAGW-1:0]  resp_tag_q;
    logic [15:0]      resp_o_q;
    logic             resp_nan_q, resp_snan_q;

    // round-robin pointer holds the last granted index
    logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;

    logic             adv1, adv2, found, accept;
    logic [IDW-1:0]   grant;

    // compare unit outputs
    logic [15:0]      cmp_cond;
    logic             cmp_nan, cmp_snan;

    assign adv2   = ce & s1_v_q & (~resp_valid_q | resp_ready);
    assign adv1   = ce & (~s1_v_q | adv2);
    assign accept = adv1 & found;

    // search requesters starting one past the last winner, wrapping modulo NREQ
    always_comb begin
        found = 1'b0;
        grant = '0;
        for (int k = 1; k <= NREQ; k++) begin
            logic [IDW-1:0] cand;
            cand = IDW'((int'(rr_ptr_q) + k) % NREQ);
            if (!found && req_valid[cand]) begin
                found = 1'b1;
                grant = cand;
            end
        end
    end

    assign req_ready = accept ? (NREQ'(1) << grant) : '0;
    assign rr_ptr_d  = accept ? grant : rr_ptr_q;

    // fpCompare32: IEEE-754 single compare; +0 and -0 compare equal, NaN is unordered
    always_comb begin
        logic a_nan, b_nan, unord, both_zero, raw_eq, raw_lt;
        logic eq, lt, gt;
        a_nan     = (&s1_a_q[30:23]) & (|s1_a_q[22:0]);
        b_nan     = (&s1_b_q[30:23]) & (|s1_b_q[22:0]);
        unord     = a_nan | b_nan;
        both_zero = ~(|s1_a_q[30:0]) & ~(|s1_b_q[30:0]);
        raw_eq    = both_zero | (s1_a_q == s1_b_q);
        if (both_zero)
            raw_lt = 1'b0;
        else if (s1_a_q[31] != s1_b_q[31])
            raw_lt = s1_a_q[31];
        else if (!s1_a_q[31])
            raw_lt = s1_a_q[30:0] < s1_b_q[30:0];
        else
            raw_lt = s1_a_q[30:0] > s1_b_q[30:0];
        eq = ~unord & raw_eq;
        lt = ~unord & raw_lt;
        gt = ~unord & ~raw_eq & ~raw_lt;
        // {rsvd[15:13], ord, uge, ge, ueq, ult, rsvd, ugt, gt, unord, ne, le, lt, eq}
        cmp_cond = {3'b000, ~unord, unord | eq | gt, eq | gt, unord | eq, unord | lt,
                    1'b0, unord | gt, gt, unord, ~eq, eq | lt, lt, eq};
        cmp_nan  = unord;
        cmp_snan = (a_nan & ~s1_a_q[22]) | (b_nan & ~s1_b_q[22]);
    end

    // issue stage and arbitration pointer
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_v_q   <= 1'b0;
            s1_a_q   <= '0;
            s1_b_q   <= '0;
            s1_id_q  <= '0;
            s1_tag_q <= '0;
            rr_ptr_q <= IDW'(NREQ - 1);
        end else begin
            rr_ptr_q <= rr_ptr_d;
            if (adv1) begin
                s1_v_q <= accept;
                if (accept) begin
                    s1_a_q   <= req_a[32*grant +: 32];
                    s1_b_q   <= req_b[32*grant +: 32];
                    s1_tag_q <= req_tag[TAGW*grant +: TAGW];
                    s1_id_q  <= grant;
                end
            end
        end
    end

    // response stage holds its entry until the consumer takes it
    always_ff @(posedge clk) begin
        if (rst) begin
            resp_valid_q <= 1'b0;
            resp_id_q    <= '0;
            resp_tag_q   <= '0;
            resp_o_q     <= '0;
            resp_nan_q   <= 1'b0;
            resp_snan_q  <= 1'b0;
        end else if (adv2) begin
            resp_valid_q <= 1'b1;
            resp_id_q    <= s1_id_q;
            resp_tag_q   <= s1_tag_q;
            resp_o_q     <= cmp_cond;
            resp_nan_q   <= cmp_nan;
            resp_snan_q  <= cmp_snan;
        end else if (ce && resp_valid_q && resp_ready) begin
            resp_valid_q <= 1'b0;
        end
    end

    assign resp_valid = resp_valid_q;
    assign resp_id    = resp_id_q;
    assign resp_tag   = resp_tag_q;
    assign resp_o     = resp_o_q;
    assign resp_nan   = resp_nan_q;
    assign resp_snan  = resp_snan_q;
    assign busy       = s1_v_q | resp_valid_q;

endmodule
